// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter needs at least one bit even when a single step covers the word.
  function automatic int calc_cnt_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, no state, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit add/subtract, DIGIT bits per clock; done pulses STEPS cycles after start.
// start is honoured only in IDLE or DONE and ignored while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] s_shift;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] chain_s;
  logic             accept;
  logic             last_step;

  assign chain_c[0] = carry;

  genvar i;
  for (i = 0; i < DIGIT; i++) begin : g_cell
    full_adder u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (chain_c[i]),
      .s    (chain_s[i]),
      .cout (chain_c[i+1])
    );
  end

  // New digit enters at the top so the LSB digit lands at bit 0 after STEPS shifts.
  assign s_shift = (S >> DIGIT) | (WIDTH'(chain_s) << (WIDTH - DIGIT));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a  <= A;
        op_b  <= Sub ? ~B : B;
        carry <= Sub | Cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        op_a  <= op_a >> DIGIT;
        op_b  <= op_b >> DIGIT;
        S     <= s_shift;
        carry <= chain_c[DIGIT];
        cnt   <= cnt + CNT_W'(1);
        if (last_step) begin
          Cout <= chain_c[DIGIT];
          Ovf  <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at (8,1), (8,4) and (4,2) against an integer arithmetic reference.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8, DIGIT=1
  logic       st8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic       busy8, done8, co8, ov8;
  // WIDTH=8, DIGIT=4
  logic       st84 = 0, sub84 = 0, cin84 = 0;
  logic [7:0] a84 = 0, b84 = 0, s84;
  logic       busy84, done84, co84, ov84;
  // WIDTH=4, DIGIT=2
  logic       st42 = 0, sub42 = 0, cin42 = 0;
  logic [3:0] a42 = 0, b42 = 0, s42;
  logic       busy42, done42, co42, ov42;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .Sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .Cout(co8), .Ovf(ov8));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut84 (
    .clk(clk), .rst(rst), .start(st84), .Sub(sub84), .A(a84), .B(b84), .Cin(cin84),
    .busy(busy84), .done(done84), .S(s84), .Cout(co84), .Ovf(ov84));

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut42 (
    .clk(clk), .rst(rst), .start(st42), .Sub(sub42), .A(a42), .B(b42), .Cin(cin42),
    .busy(busy42), .done(done42), .S(s42), .Cout(co42), .Ovf(ov42));

  // Reference: unsigned and signed integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic sub,
                                output logic [7:0] s, output logic co, output logic ov);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    if (sub) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(cin);
      co = (r >= (1 << w));
      sr = sa + sb + int'(cin);
    end
    s  = 8'(r & ((1 << w) - 1));
    ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
  endfunction

  // Called on the negedge right after the start edge; returns on the done negedge.
  task automatic wait8(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                      output int lat, output int bcnt);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; st8 = 1;
    @(negedge clk);
    st8 = 0;
    wait8(lat, bcnt);
  endtask

  task automatic run84(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       output int lat);
    @(negedge clk);
    a84 = a; b84 = b; cin84 = cin; sub84 = sub; st84 = 1;
    @(negedge clk);
    st84 = 0; lat = 0;
    while (!done84 && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic run42(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub,
                       output int lat);
    @(negedge clk);
    a42 = a; b42 = b; cin42 = cin; sub42 = sub; st42 = 1;
    @(negedge clk);
    st42 = 0; lat = 0;
    while (!done42 && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    n_tests++;
    if ({busy8, done8, s8, co8, ov8} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b S=%h Cout=%b Ovf=%b, want all 0", busy8, done8, s8, co8, ov8);
    end
    n_tests++;
    if ({busy84, done84, s84, co84, ov84} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset84: busy=%b done=%b S=%h Cout=%b Ovf=%b, want all 0", busy84, done84, s84, co84, ov84);
    end
    n_tests++;
    if ({busy42, done42, s42, co42, ov42} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset42: busy=%b done=%b S=%h Cout=%b Ovf=%b, want all 0", busy42, done42, s42, co42, ov42);
    end
  endtask

  typedef struct packed {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       co, ov;
  } dvec_t;

  task automatic test_directed();
    dvec_t dv [5];
    int lat, bcnt;
    dv[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    dv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    dv[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    dv[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    dv[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run8(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, lat, bcnt);
      n_tests++;
      if ({s8, co8, ov8} !== {dv[i].s, dv[i].co, dv[i].ov} || lat != 8 || bcnt != 8) begin
        n_fail++;
        $display("FAIL directed[%0d]: S=%h Cout=%b Ovf=%b lat=%0d busy=%0d, want S=%h Cout=%b Ovf=%b lat=8 busy=8",
                 i, s8, co8, ov8, lat, bcnt, dv[i].s, dv[i].co, dv[i].ov);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h13; cin8 = 0; sub8 = 0; st8 = 1;
    @(negedge clk);
    st8 = 0; lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1; st8 = 1;
      end else begin
        st8 = 0;
      end
    end
    n_tests++;
    if (s8 !== 8'h34 || co8 !== 1'b0 || lat != 8) begin
      n_fail++;
      $display("FAIL start_ignored: S=%h Cout=%b lat=%0d, want S=34 Cout=0 lat=8", s8, co8, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run8(8'h10, 8'h20, 1'b0, 1'b0, lat, bcnt);
    n_tests++;
    if (s8 !== 8'h30 || lat != 8) begin
      n_fail++;
      $display("FAIL b2b_first: S=%h lat=%0d, want S=30 lat=8", s8, lat);
    end
    a8 = 8'h02; b8 = 8'h03; cin8 = 0; sub8 = 0; st8 = 1;
    @(negedge clk);
    st8 = 0;
    wait8(lat, bcnt);
    n_tests++;
    if (s8 !== 8'h05 || lat != 8 || bcnt != 8) begin
      n_fail++;
      $display("FAIL b2b_second: S=%h lat=%0d busy=%0d, want S=05 lat=8 busy=8", s8, lat, bcnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt, seen;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; cin8 = 0; sub8 = 0; st8 = 1;
    @(negedge clk);
    st8 = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b S=%h, want busy=0 done=0 S=00", busy8, done8, s8);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d cycles with busy/done after abort, want 0", seen);
    end
    run8(8'h3C, 8'h0A, 1'b1, 1'b0, lat, bcnt);
    n_tests++;
    if (s8 !== 8'h47 || co8 !== 1'b0 || lat != 8) begin
      n_fail++;
      $display("FAIL reset_mid_restart: S=%h Cout=%b lat=%0d, want S=47 Cout=0 lat=8", s8, co8, lat);
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, es;
    logic cin, sub, eco, eov;
    int lat, bcnt;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      model(8, a, b, cin, sub, es, eco, eov);
      run8(a, b, cin, sub, lat, bcnt);
      n_tests++;
      if ({s8, co8, ov8} !== {es, eco, eov} || lat != 8) begin
        n_fail++;
        $display("FAIL random8 a=%h b=%h cin=%b sub=%b: S=%h Cout=%b Ovf=%b lat=%0d, want S=%h Cout=%b Ovf=%b lat=8",
                 a, b, cin, sub, s8, co8, ov8, lat, es, eco, eov);
      end
    end
  endtask

  task automatic test_digit4();
    logic [7:0] a, b, es;
    logic cin, sub, eco, eov;
    int lat;
    run84(8'hF0, 8'h10, 1'b0, 1'b0, lat);
    n_tests++;
    if (s84 !== 8'h00 || co84 !== 1'b1 || lat != 2) begin
      n_fail++;
      $display("FAIL digit4_dir: S=%h Cout=%b lat=%0d, want S=00 Cout=1 lat=2", s84, co84, lat);
    end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      model(8, a, b, cin, sub, es, eco, eov);
      run84(a, b, cin, sub, lat);
      n_tests++;
      if ({s84, co84, ov84} !== {es, eco, eov} || lat != 2) begin
        n_fail++;
        $display("FAIL digit4 a=%h b=%h cin=%b sub=%b: S=%h Cout=%b Ovf=%b lat=%0d, want S=%h Cout=%b Ovf=%b lat=2",
                 a, b, cin, sub, s84, co84, ov84, lat, es, eco, eov);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [7:0] es;
    logic eco, eov;
    int lat, nbad;
    nbad = 0;
    for (int sub = 0; sub < 2; sub++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          for (int cin = 0; cin < 2; cin++) begin
            model(4, 8'(a), 8'(b), 1'(cin), 1'(sub), es, eco, eov);
            run42(4'(a), 4'(b), 1'(cin), 1'(sub), lat);
            n_tests++;
            if ({s42, co42, ov42} !== {es[3:0], eco, eov} || lat != 2) begin
              n_fail++;
              if (nbad < 10)
                $display("FAIL w4 a=%h b=%h cin=%0d sub=%0d: S=%h Cout=%b Ovf=%b lat=%0d, want S=%h Cout=%b Ovf=%b lat=2",
                         a, b, cin, sub, s42, co42, ov42, lat, es[3:0], eco, eov);
              nbad++;
            end
          end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_random8();
    test_digit4();
    test_exhaustive_w4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
